// File: rtl/dna_pkg.sv
// Shared types for the DNA sequence player: base codes, player states and
// the base-to-line decode used to drive the A/G/C/T outputs.
package dna_pkg;

  typedef enum logic [1:0] {
    BASE_A = 2'b00,
    BASE_G = 2'b01,
    BASE_C = 2'b10,
    BASE_T = 2'b11
  } base_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_GAP,
    ST_FINISH
  } state_t;

  // Returns {A,G,C,T}
  function automatic logic [3:0] base_to_onehot(base_t b);
    case (b)
      BASE_A:  return 4'b1000;
      BASE_G:  return 4'b0100;
      BASE_C:  return 4'b0010;
      BASE_T:  return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dna_phase_timer.sv
// Loadable down-counter that times the HOLD and GAP phases; zero is high
// once the loaded count has been consumed.
module dna_phase_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/dna_sequence_player.sv
// Plays a stored base sequence as one-hot A/G/C/T pulses separated by gaps.
// Define DNA_PLAYER_LOOP_EN to repeat playback seamlessly while start is held.
module dna_sequence_player
  import dna_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [$clog2(DEPTH)-1:0]   wr_addr,
  input  logic [1:0]                 wr_base,
  input  logic [$clog2(DEPTH+1)-1:0] len,
  input  logic                       start,
  output logic                       A,
  output logic                       G,
  output logic                       C,
  output logic                       T,
  output logic                       busy,
  output logic                       done
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LW    = $clog2(DEPTH + 1);
  localparam int MAXHG = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW    = $clog2(MAXHG + 1);

  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD  = TW'(GAP_CYCLES - 1);
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  base_t         mem_q [DEPTH];
  state_t        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [LW-1:0] eff_len_q, eff_len_d;
  logic [LW-1:0] len_clip;
  logic [3:0]    line_q, line_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          last_base;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;
  logic          tmr_zero;

  // Storage is data only: no reset, and writes are locked out during playback
  always_ff @(posedge clk) begin
    if (wr_en && (state_q == ST_IDLE) && (int'(wr_addr) < DEPTH)) begin
      mem_q[wr_addr] <= base_t'(wr_base);
    end
  end

  dna_phase_timer #(
    .W(TW)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  assign len_clip  = (len > DEPTH_L) ? DEPTH_L : len;
  assign last_base = (LW'(idx_q) == (eff_len_q - LW'(1)));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    eff_len_d = eff_len_q;
    line_d    = '0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    tmr_load  = 1'b0;
    tmr_val   = HOLD_LD;

    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          eff_len_d = len_clip;
          idx_d     = '0;
          if (len_clip == '0) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_HOLD;
            busy_d   = 1'b1;
            tmr_load = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (tmr_zero) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = GAP_LD;
        end
      end
      ST_GAP: begin
        if (tmr_zero) begin
          if (!last_base) begin
            idx_d    = idx_q + AW'(1);
            state_d  = ST_HOLD;
            tmr_load = 1'b1;
`ifdef DNA_PLAYER_LOOP_EN
          end else if (start) begin
            idx_d    = '0;
            state_d  = ST_HOLD;
            tmr_load = 1'b1;
`endif
          end else begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Lines are registered, so decode the base the next state will show
    if (state_d == ST_HOLD) begin
      line_d = base_to_onehot(mem_q[idx_d]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      eff_len_q <= '0;
      line_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      eff_len_q <= eff_len_d;
      line_q    <= line_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign {A, G, C, T} = line_q;
  assign busy         = busy_q;
  assign done         = done_q;

endmodule

// File: tb/tb_dna_sequence_player.sv
// Bench for dna_sequence_player: two instances (H=G=4 and H=G=1) checked
// cycle by cycle against an arithmetic playback model.
module tb_dna_sequence_player;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en0, wr_en1;
  logic [2:0] wr_addr;
  logic [1:0] wr_base;
  logic [3:0] len;
  logic       start0, start1;
  logic       A0, G0, C0, T0, busy0, done0;
  logic       A1, G1, C1, T1, busy1, done1;

  logic [1:0] mem_m [8];
  int         n_chk  = 0;
  int         n_pass = 0;

  always #5 clk = ~clk;

  dna_sequence_player #(.DEPTH(8), .HOLD_CYCLES(4), .GAP_CYCLES(4)) dut0 (
    .clk(clk), .reset(reset), .wr_en(wr_en0), .wr_addr(wr_addr),
    .wr_base(wr_base), .len(len), .start(start0),
    .A(A0), .G(G0), .C(C0), .T(T0), .busy(busy0), .done(done0)
  );

  dna_sequence_player #(.DEPTH(8), .HOLD_CYCLES(1), .GAP_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .wr_en(wr_en1), .wr_addr(wr_addr),
    .wr_base(wr_base), .len(len), .start(start1),
    .A(A1), .G(G1), .C(C1), .T(T1), .busy(busy1), .done(done1)
  );

  task automatic check(input string tag, input logic [5:0] got, input logic [5:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got={AGCT,busy,done}=%b expected=%b at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [3:0] oh(input logic [1:0] b);
    return 4'b1000 >> b;
  endfunction

  // Expected {A,G,C,T,busy,done} t cycles after the edge where start was
  // driven high; start is sampled high on edges 1..d, then low.
  function automatic logic [5:0] exp_out(input int t, input int h, input int g,
                                         input int n, input int d);
    int L, P, passes, tt;
    L = n * (h + g);
`ifdef DNA_PLAYER_LOOP_EN
    if (n > 0) begin
      passes = (d - 1) / L + 1;
      if (t <= passes * L) begin
        tt = (t - 1) % L;
        return {((tt % (h + g)) < h) ? oh(mem_m[tt / (h + g)]) : 4'b0000, 2'b10};
      end
      if (t == passes * L + 1) return 6'b000001;
      return 6'b000000;
    end
`endif
    P      = L + 2;
    passes = (d - 1) / P + 1;
    if (t > passes * P) return 6'b000000;
    tt = (t - 1) % P;
    if (tt < L) return {((tt % (h + g)) < h) ? oh(mem_m[tt / (h + g)]) : 4'b0000, 2'b10};
    if (tt == L) return 6'b000001;
    return 6'b000000;
  endfunction

  function automatic logic [5:0] obs(input int sel);
    return (sel == 0) ? {A0, G0, C0, T0, busy0, done0} : {A1, G1, C1, T1, busy1, done1};
  endfunction

  task automatic wr(input int a, input logic [1:0] b);
    @(posedge clk); #1;
    wr_addr = 3'(a); wr_base = b; wr_en0 = 1'b1; wr_en1 = 1'b1;
    @(posedge clk); #1;
    wr_en0 = 1'b0; wr_en1 = 1'b0;
    mem_m[a] = b;
  endtask

  // Play on one instance; wt>0 pokes a write to address 0 mid-playback
  task automatic run(input string tag, input int sel, input int l, input int d, input int wt);
    int h, n, tmax;
    h    = (sel == 0) ? 4 : 1;
    n    = (l > 8) ? 8 : l;
    tmax = d + 2 * (n * 2 * h + 2) + 4;
    @(posedge clk); #1;
    len = 4'(l);
    if (sel == 0) start0 = 1'b1; else start1 = 1'b1;
    for (int t = 1; t <= tmax; t++) begin
      @(posedge clk); #1;
      if (t == d) begin start0 = 1'b0; start1 = 1'b0; end
      if (wt > 0 && t == wt) begin wr_addr = 3'd0; wr_base = ~mem_m[0]; wr_en0 = 1'b1; end
      if (wt > 0 && t == wt + 1) wr_en0 = 1'b0;
      @(negedge clk);
      check(tag, obs(sel), exp_out(t, h, h, n, d));
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; wr_en0 = 1'b0; wr_en1 = 1'b0; wr_addr = '0; wr_base = '0;
    len = '0; start0 = 1'b0; start1 = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_hold0", obs(0), 6'b0);
    check("reset_hold1", obs(1), 6'b0);
    #1 reset = 1'b0;
    repeat (2) @(negedge clk);
    check("post_reset0", obs(0), 6'b0);
    check("post_reset1", obs(1), 6'b0);

    // G,G,T,C then len=4 on the H=G=4 instance
    wr(0, 2'b01); wr(1, 2'b01); wr(2, 2'b11); wr(3, 2'b10);
    run("ggtc", 0, 4, 1, 0);

    run("len0_main", 0, 0, 1, 0);
    run("len0_small", 1, 0, 1, 0);

    // G,G,T,C,A,G with len=6 on the H=G=1 instance
    wr(4, 2'b00); wr(5, 2'b01);
    run("ggtcag_small", 1, 6, 1, 0);

    for (int a = 0; a < 8; a++) wr(a, 2'($urandom_range(0, 3)));
    run("len12_main", 0, 12, 1, 0);
    run("len12_small", 1, 12, 1, 0);

    // start held across passes with a write attempt during playback
    run("held_write", 0, 4, 45, 5);
    run("after_write", 0, 2, 1, 0);

    // reset in the HOLD phase of base 1
    @(posedge clk); #1;
    len = 4'd4; start0 = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      @(posedge clk); #1;
      if (t == 1) start0 = 1'b0;
      @(negedge clk);
      check("pre_reset", obs(0), exp_out(t, 4, 4, 4, 1));
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1 check("async_reset", obs(0), 6'b0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    for (int t = 0; t < 40; t++) begin
      @(negedge clk);
      check("after_abort", obs(0), 6'b0);
    end
    run("replay", 0, 4, 1, 0);

    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 8; a++) wr(a, 2'($urandom_range(0, 3)));
      run("rand", int'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
          (r % 3 == 0) ? int'($urandom_range(1, 40)) : 1, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
